// File: rtl/adc_spi_resp.sv
// SPI responder modelling an 8-channel 12-bit serial A2D; the response is pipelined by one transaction.
// Optional: define ADC_SPI_RESP_NOISE_EN to add LFSR dither (-2..+1 LSB, saturated) to each loaded sample.
module adc_spi_resp #(
  parameter int         SYNC_STAGES = 2,
  parameter logic [2:0] RESET_CH    = 3'd0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        SS_n,
  input  logic        SCLK,
  input  logic        MOSI,
  output logic        MISO,
  input  logic [95:0] ain,
  output logic [2:0]  cmd_ch,
  output logic        busy,
  output logic        xfer_done,
  output logic        xfer_abort
);

  typedef enum logic [1:0] {WAIT_HI, IDLE, ACTIVE} state_t;

  localparam int SETTLE = SYNC_STAGES + 1;
  localparam int SCW    = $clog2(SETTLE + 1);

  state_t state, state_nxt;

  logic [SYNC_STAGES-1:0] ss_pipe, sclk_pipe, mosi_pipe;
  logic                   ss_prev, sclk_prev;
  logic                   ss_sync, sclk_sync, mosi_sync;
  logic                   ss_fall, ss_rise, sclk_rise, sclk_fall;
  logic [SCW-1:0]         settle_cnt;
  logic                   settled;
  logic [15:0]            tx;
  logic [2:0]             rx_ch;
  logic [4:0]             bit_cnt;
  logic [11:0]            ain_sel, load_val;
  logic                   load;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ss_pipe   <= '1;
      sclk_pipe <= '1;
      mosi_pipe <= '1;
      ss_prev   <= 1'b1;
      sclk_prev <= 1'b1;
    end else begin
      ss_pipe   <= {ss_pipe[SYNC_STAGES-2:0], SS_n};
      sclk_pipe <= {sclk_pipe[SYNC_STAGES-2:0], SCLK};
      mosi_pipe <= {mosi_pipe[SYNC_STAGES-2:0], MOSI};
      ss_prev   <= ss_pipe[SYNC_STAGES-1];
      sclk_prev <= sclk_pipe[SYNC_STAGES-1];
    end
  end

  assign ss_sync   = ss_pipe[SYNC_STAGES-1];
  assign sclk_sync = sclk_pipe[SYNC_STAGES-1];
  assign mosi_sync = mosi_pipe[SYNC_STAGES-1];
  assign ss_fall   = ss_prev & ~ss_sync;
  assign ss_rise   = ~ss_prev & ss_sync;
  assign sclk_rise = ~sclk_prev & sclk_sync;
  assign sclk_fall = sclk_prev & ~sclk_sync;

  // The synchronizers reset to 1, so a held-low SS_n only becomes visible once they have flushed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      settle_cnt <= '0;
    else if (!settled)
      settle_cnt <= settle_cnt + 1'b1;
  end
  assign settled = (settle_cnt == SCW'(SETTLE));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= WAIT_HI;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      WAIT_HI: if (settled && ss_sync) state_nxt = IDLE;
      IDLE:    if (ss_fall)            state_nxt = ACTIVE;
      ACTIVE:  if (ss_rise)            state_nxt = IDLE;
      default:                         state_nxt = WAIT_HI;
    endcase
  end

  always_comb begin
    busy = (state == ACTIVE);
    MISO = busy & tx[15];
  end

  assign load    = (state == IDLE) && ss_fall;
  assign ain_sel = ain[int'(cmd_ch)*12 +: 12];

`ifdef ADC_SPI_RESP_NOISE_EN
  logic [15:0]        lfsr;
  logic               lfsr_fb;
  logic signed [13:0] noisy;

  assign lfsr_fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    lfsr <= 16'hACE1;
    else if (load) lfsr <= {lfsr[14:0], lfsr_fb};
  end

  always_comb begin
    noisy = $signed({2'b00, ain_sel}) + $signed({{12{lfsr[1]}}, lfsr[1:0]});
    if (noisy < 0)                  load_val = 12'd0;
    else if (noisy > 14'sd4095)     load_val = 12'hFFF;
    else                            load_val = noisy[11:0];
  end
`else
  assign load_val = ain_sel;
`endif

  // Only command bits 13:11 matter; they arrive as the 3rd..5th bits on the wire.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx         <= '0;
      rx_ch      <= '0;
      bit_cnt    <= '0;
      cmd_ch     <= RESET_CH;
      xfer_done  <= 1'b0;
      xfer_abort <= 1'b0;
    end else begin
      xfer_done  <= 1'b0;
      xfer_abort <= 1'b0;
      if (load) begin
        tx      <= {4'b0000, load_val};
        bit_cnt <= '0;
      end else if (state == ACTIVE) begin
        if (ss_rise) begin
          if (bit_cnt == 5'd16) begin
            cmd_ch    <= rx_ch;
            xfer_done <= 1'b1;
          end else begin
            xfer_abort <= 1'b1;
          end
        end else begin
          if (sclk_rise && bit_cnt < 5'd16) begin
            if (bit_cnt >= 5'd2 && bit_cnt <= 5'd4)
              rx_ch <= {rx_ch[1:0], mosi_sync};
            bit_cnt <= bit_cnt + 5'd1;
          end
          if (sclk_fall && bit_cnt != 5'd0)
            tx <= {tx[14:0], 1'b0};
        end
      end
    end
  end

endmodule

// File: tb/tb_adc_spi_resp.sv
// Bench for adc_spi_resp: vector table, hand-written corner sequences, and randomized transactions vs a model.
`timescale 1ns/1ps
module tb_adc_spi_resp;

  logic        clk = 1'b0;
  logic        rst_n, ss_n, sclk, mosi;
  logic        miso, busy, xfer_done, xfer_abort;
  logic [95:0] ain;
  logic [2:0]  cmd_ch;

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;
  int abort_cnt = 0;

  // Reference model state: channel to answer next, and dither generator.
  int          model_ch;
  logic [15:0] model_lfsr;

  always #5 clk = ~clk;

  adc_spi_resp dut (
    .clk(clk), .rst_n(rst_n), .SS_n(ss_n), .SCLK(sclk), .MOSI(mosi), .MISO(miso),
    .ain(ain), .cmd_ch(cmd_ch), .busy(busy), .xfer_done(xfer_done), .xfer_abort(xfer_abort)
  );

  always @(negedge clk) begin
    if (xfer_done)  done_cnt++;
    if (xfer_abort) abort_cnt++;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic model_load(input logic [11:0] raw, output logic [11:0] v);
`ifdef ADC_SPI_RESP_NOISE_EN
    int s;
    s = int'(raw) + ((model_lfsr[1:0] >= 2) ? int'(model_lfsr[1:0]) - 4 : int'(model_lfsr[1:0]));
    if (s < 0) s = 0;
    if (s > 4095) s = 4095;
    v = s[11:0];
    model_lfsr = {model_lfsr[14:0], model_lfsr[15] ^ model_lfsr[13] ^ model_lfsr[12] ^ model_lfsr[10]};
`else
    v = raw;
`endif
  endtask

  task automatic model_reset();
    model_ch   = 0;
    model_lfsr = 16'hACE1;
  endtask

  task automatic xfer_bit(input logic mosi_b, output logic miso_b);
    sclk = 1'b0;
    mosi = mosi_b;
    wait_clks(6);
    miso_b = miso;
    sclk = 1'b1;
    wait_clks(6);
  endtask

  task automatic xfer(input logic [19:0] bits, input int nbits,
                      output logic [15:0] word, output logic tail, output logic busy_seen);
    logic b;
    word = '0; tail = 1'b0; busy_seen = 1'b0;
    ss_n = 1'b0;
    wait_clks(6);
    for (int i = 0; i < nbits; i++) begin
      xfer_bit(bits[19-i], b);
      if (i < 16) word = {word[14:0], b};
      else        tail = tail | b;
      if (i == 0) busy_seen = busy;
    end
    ss_n = 1'b1;
    wait_clks(8);
  endtask

  task automatic run_and_check(input logic [19:0] bits, input int nbits, input string tag,
                               output logic [15:0] got);
    logic [11:0] v;
    logic [15:0] exp;
    logic        tail, bsy;
    int          d0, a0, n16;
    model_load(ain[model_ch*12 +: 12], v);
    exp = {4'b0000, v};
    d0 = done_cnt; a0 = abort_cnt;
    xfer(bits, nbits, got, tail, bsy);
    n16 = (nbits < 16) ? nbits : 16;
    chk({tag, " miso_word"}, 32'(got), 32'(exp >> (16 - n16)));
    if (nbits > 16) chk({tag, " miso_tail_zero"}, 32'(tail), 32'd0);
    chk({tag, " busy"}, 32'(bsy), 32'd1);
    if (nbits >= 16) model_ch = int'(bits[17:15]);
    chk({tag, " done_pulses"}, 32'(done_cnt - d0), (nbits >= 16) ? 32'd1 : 32'd0);
    chk({tag, " abort_pulses"}, 32'(abort_cnt - a0), (nbits >= 16) ? 32'd0 : 32'd1);
    chk({tag, " cmd_ch"}, 32'(cmd_ch), 32'(model_ch));
  endtask

  typedef struct {
    logic [15:0] cmd;
    logic [3:0]  trail;
    int          nbits;
    int          ch;
    logic [11:0] val;
    logic [15:0] exp_word;
    logic [2:0]  exp_ch;
  } vec_t;

  vec_t vecs[4];

  initial begin
    logic [15:0] got;
    logic [11:0] v;
    logic        b;
    int          d0, a0, nb;

    vecs[0] = '{16'h1800, 4'h0, 16, 0, 12'hABC, 16'h0ABC, 3'd3};
    vecs[1] = '{16'h2800, 4'h0, 16, 3, 12'h123, 16'h0123, 3'd5};
    vecs[2] = '{16'h1800, 4'h0,  7, 5, 12'hFFF, 16'h0007, 3'd5};
    vecs[3] = '{16'h3000, 4'hF, 20, 5, 12'hFFF, 16'h0FFF, 3'd6};

    rst_n = 1'b0; ss_n = 1'b1; sclk = 1'b1; mosi = 1'b0;
    ain = {$urandom, $urandom, $urandom};
    model_reset();
    wait_clks(3);
    chk("reset miso", 32'(miso), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset cmd_ch", 32'(cmd_ch), 32'd0);
    chk("reset done", 32'(xfer_done), 32'd0);
    chk("reset abort", 32'(xfer_abort), 32'd0);
    rst_n = 1'b1;
    wait_clks(8);

    for (int k = 0; k < 4; k++) begin
      ain[vecs[k].ch*12 +: 12] = vecs[k].val;
      run_and_check({vecs[k].cmd, vecs[k].trail}, vecs[k].nbits, $sformatf("vec%0d", k), got);
`ifndef ADC_SPI_RESP_NOISE_EN
      chk($sformatf("vec%0d table_word", k), 32'(got), 32'(vecs[k].exp_word));
`endif
      chk($sformatf("vec%0d table_ch", k), 32'(cmd_ch), 32'(vecs[k].exp_ch));
    end

    // ain changes after the load must not reach the bits in flight.
    run_and_check({16'h2800, 4'h0}, 16, "pre_ainchg", got);
    ain[5*12 +: 12] = 12'h555;
    model_load(12'h555, v);
    ss_n = 1'b0;
    wait_clks(5);
    ain[5*12 +: 12] = 12'h0AA;
    wait_clks(1);
    got = '0;
    for (int i = 0; i < 16; i++) begin
      xfer_bit(1'b0, b);
      got = {got[14:0], b};
    end
    ss_n = 1'b1;
    wait_clks(8);
    model_ch = 0;
    chk("ainchg miso_word", 32'(got), 32'({4'b0000, v}));
    chk("ainchg cmd_ch", 32'(cmd_ch), 32'd0);

    // Reset in the middle of a transaction: the remaining bits must be ignored.
    ss_n = 1'b0;
    wait_clks(6);
    for (int i = 0; i < 8; i++) xfer_bit(1'b1, b);
    rst_n = 1'b0;
    wait_clks(2);
    chk("midrst miso", 32'(miso), 32'd0);
    chk("midrst busy", 32'(busy), 32'd0);
    chk("midrst cmd_ch", 32'(cmd_ch), 32'd0);
    chk("midrst done", 32'(xfer_done), 32'd0);
    chk("midrst abort", 32'(xfer_abort), 32'd0);
    rst_n = 1'b1;
    model_reset();
    d0 = done_cnt; a0 = abort_cnt;
    for (int i = 0; i < 8; i++) begin
      xfer_bit(1'b1, b);
      if (i == 4) chk("midrst busy_after", 32'(busy), 32'd0);
    end
    ss_n = 1'b1;
    wait_clks(8);
    chk("midrst no_done", 32'(done_cnt - d0), 32'd0);
    chk("midrst no_abort", 32'(abort_cnt - a0), 32'd0);
    ain[0 +: 12] = 12'h3C5;
    run_and_check({16'h3800, 4'h0}, 16, "postrst", got);

    for (int k = 0; k < 40; k++) begin
      ain = {$urandom, $urandom, $urandom};
      nb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 20)) : 16;
      run_and_check(20'($urandom), nb, $sformatf("rand%0d", k), got);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
